// File: rtl/mu0_control.sv
// MU0 sequencing FSM: alternates fetch and execute, steers the datapath muxes,
// register enables and memory strobes, and bounds every memory wait.
module mu0_control #(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned WCNT_W     = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] F,
  input  logic       N,
  input  logic       Z,
  input  logic       Mem_rdy,
  output logic       X_sel,
  output logic       Y_sel,
  output logic       Addr_sel,
  output logic       PC_En,
  output logic       IR_En,
  output logic       Acc_En,
  output logic       MEM_rd,
  output logic       MEM_wr,
  output logic [1:0] M,
  output logic       Halted,
  output logic       Fault
);

  typedef enum logic [1:0] {StFetch, StExec, StHalt} state_e;

  localparam logic [WCNT_W-1:0] WcntLast = WCNT_W'(WAIT_LIMIT - 1);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              fault_q, fault_d;
  logic              mem_acc;

  // State, wait counter and sticky fault flag.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StFetch;
      wcnt_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      fault_q <= fault_d;
    end
  end

  // Output decode, next state and memory-wait supervision.
  always_comb begin
    X_sel    = 1'b0;
    Y_sel    = 1'b0;
    Addr_sel = 1'b0;
    PC_En    = 1'b0;
    IR_En    = 1'b0;
    Acc_En   = 1'b0;
    MEM_rd   = 1'b0;
    MEM_wr   = 1'b0;
    M        = 2'd0;
    Halted   = 1'b0;
    Fault    = fault_q;
    mem_acc  = 1'b0;
    state_d  = state_q;
    wcnt_d   = '0;
    fault_d  = fault_q;

    unique case (state_q)
      StFetch: begin
        MEM_rd  = 1'b1;
        M       = 2'd2;
        mem_acc = 1'b1;
        if (Mem_rdy) begin
          IR_En   = 1'b1;
          PC_En   = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StFetch;
        case (F)
          4'd0: begin
            Addr_sel = 1'b1;
            MEM_rd   = 1'b1;
            Acc_En   = Mem_rdy;
            mem_acc  = 1'b1;
          end
          4'd1: begin
            Addr_sel = 1'b1;
            MEM_wr   = 1'b1;
            mem_acc  = 1'b1;
          end
          4'd2, 4'd3: begin
            Addr_sel = 1'b1;
            MEM_rd   = 1'b1;
            X_sel    = 1'b1;
            M        = (F == 4'd2) ? 2'd1 : 2'd3;
            Acc_En   = Mem_rdy;
            mem_acc  = 1'b1;
          end
          4'd4: begin
            Y_sel = 1'b1;
            PC_En = 1'b1;
          end
          4'd5: begin
            Y_sel = 1'b1;
            PC_En = ~N;
          end
          4'd6: begin
            Y_sel = 1'b1;
            PC_En = ~Z;
          end
          4'd7:    state_d = StHalt;
          default: ;
        endcase
        // Memory opcodes hold here until the access completes.
        if (mem_acc && !Mem_rdy) state_d = StExec;
      end
      StHalt: Halted = 1'b1;
      default: state_d = StFetch;
    endcase

    // Count stalled strobe cycles; the last allowed one without ready faults.
    if (mem_acc && !Mem_rdy) begin
      if (wcnt_q == WcntLast) begin
        fault_d = 1'b1;
        state_d = StHalt;
      end else begin
        wcnt_d = wcnt_q + WCNT_W'(1);
      end
    end

    // Reset forces every output low immediately, mid-access included.
    if (Reset) begin
      X_sel    = 1'b0;
      Y_sel    = 1'b0;
      Addr_sel = 1'b0;
      PC_En    = 1'b0;
      IR_En    = 1'b0;
      Acc_En   = 1'b0;
      MEM_rd   = 1'b0;
      MEM_wr   = 1'b0;
      M        = 2'd0;
      Halted   = 1'b0;
      Fault    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mu0_control.sv
// Directed self-checking bench for mu0_control with hand-computed output vectors.
module tb_mu0_control;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [3:0] F;
  logic       N, Z, Mem_rdy;
  logic       X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, MEM_rd, MEM_wr;
  logic [1:0] M;
  logic       Halted, Fault;
  logic [11:0] obs;

  int checks   = 0;
  int failures = 0;

  mu0_control #(.WAIT_LIMIT(15), .WCNT_W(8)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .F        (F),
    .N        (N),
    .Z        (Z),
    .Mem_rdy  (Mem_rdy),
    .X_sel    (X_sel),
    .Y_sel    (Y_sel),
    .Addr_sel (Addr_sel),
    .PC_En    (PC_En),
    .IR_En    (IR_En),
    .Acc_En   (Acc_En),
    .MEM_rd   (MEM_rd),
    .MEM_wr   (MEM_wr),
    .M        (M),
    .Halted   (Halted),
    .Fault    (Fault)
  );

  always #5 Clk = ~Clk;

  // Order: X_sel Y_sel Addr_sel PC_En IR_En Acc_En MEM_rd MEM_wr M[1:0] Halted Fault
  assign obs = {X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, MEM_rd, MEM_wr, M, Halted, Fault};

  localparam logic [11:0] VZero     = 12'b0000_0000_00_00;
  localparam logic [11:0] VFetchOk  = 12'b0001_1010_10_00;
  localparam logic [11:0] VFetchWt  = 12'b0000_0010_10_00;
  localparam logic [11:0] VLda      = 12'b0010_0110_00_00;
  localparam logic [11:0] VLdaWt    = 12'b0010_0010_00_00;
  localparam logic [11:0] VAdd      = 12'b1010_0110_01_00;
  localparam logic [11:0] VSub      = 12'b1010_0110_11_00;
  localparam logic [11:0] VJmpNo    = 12'b0100_0000_00_00;
  localparam logic [11:0] VJmpYes   = 12'b0101_0000_00_00;
  localparam logic [11:0] VSta      = 12'b0010_0001_00_00;
  localparam logic [11:0] VHalt     = 12'b0000_0000_00_10;
  localparam logic [11:0] VHaltFlt  = 12'b0000_0000_00_11;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Apply inputs just after an edge, check mid-cycle, advance to just after the next edge.
  task automatic cyc(input logic [3:0] f, input logic rdy, input logic n, input logic z,
                     input logic [11:0] exp, input string tag);
    F = f; Mem_rdy = rdy; N = n; Z = z;
    #1;
    check(tag, obs, exp);
    @(posedge Clk);
    #1;
  endtask

  task automatic instr(input logic [3:0] f, input logic n, input logic z,
                       input logic [11:0] exp, input string tag);
    cyc(f, 1'b1, n, z, VFetchOk, "fetch");
    cyc(f, 1'b1, n, z, exp, tag);
  endtask

  initial begin
    Reset = 1'b1; F = 4'd0; N = 1'b0; Z = 1'b0; Mem_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk);
      #1;
      check("reset_outputs", obs, VZero);
    end
    Reset = 1'b0;

    instr(4'd0, 1'b0, 1'b0, VLda, "exec_lda");
    instr(4'd2, 1'b0, 1'b0, VAdd, "exec_add");
    instr(4'd3, 1'b0, 1'b0, VSub, "exec_sub");
    instr(4'd5, 1'b1, 1'b0, VJmpNo, "jge_neg");
    instr(4'd5, 1'b0, 1'b0, VJmpYes, "jge_pos");
    instr(4'd6, 1'b0, 1'b1, VJmpNo, "jne_zero");
    instr(4'd6, 1'b0, 1'b0, VJmpYes, "jne_nonzero");
    instr(4'd4, 1'b1, 1'b1, VJmpYes, "jmp");

    // STA with four stalled cycles then completion.
    cyc(4'd1, 1'b1, 1'b0, 1'b0, VFetchOk, "fetch_sta");
    for (int i = 0; i < 4; i++) cyc(4'd1, 1'b0, 1'b0, 1'b0, VSta, "sta_wait");
    cyc(4'd1, 1'b1, 1'b0, 1'b0, VSta, "sta_done");

    // LDA stall shows Acc_En gated by ready.
    cyc(4'd0, 1'b1, 1'b0, 1'b0, VFetchOk, "fetch_lda");
    cyc(4'd0, 1'b0, 1'b0, 1'b0, VLdaWt, "lda_wait");
    cyc(4'd0, 1'b1, 1'b0, 1'b0, VLda, "lda_done");

    // NOP returns straight to fetch.
    instr(4'd12, 1'b0, 1'b0, VZero, "nop");
    cyc(4'd12, 1'b1, 1'b0, 1'b0, VFetchOk, "fetch_after_nop");

    // Async reset in the middle of a stalled store drops strobes at once.
    cyc(4'd1, 1'b0, 1'b0, 1'b0, VSta, "sta_before_reset");
    Reset = 1'b1;
    #1;
    check("async_reset_mid_access", obs, VZero);
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    // STP halts and ignores everything.
    instr(4'd7, 1'b0, 1'b0, VZero, "stp");
    for (int i = 0; i < 20; i++)
      cyc(4'(i), 1'(i % 2), 1'(i % 3 == 0), 1'(i % 5 == 0), VHalt, "halted");
    Reset = 1'b1;
    #1;
    check("reset_from_halt", obs, VZero);
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    // Fetch timeout: 15 strobe cycles, then halt with fault.
    for (int i = 0; i < 15; i++) cyc(4'd0, 1'b0, 1'b0, 1'b0, VFetchWt, "fetch_stall");
    cyc(4'd0, 1'b0, 1'b0, 1'b0, VHaltFlt, "timeout_fault");
    for (int i = 0; i < 3; i++) cyc(4'd0, 1'b1, 1'b0, 1'b0, VHaltFlt, "fault_sticky");
    Reset = 1'b1;
    #1;
    check("reset_clears_fault", obs, VZero);
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    // Ready arriving on the last allowed cycle completes normally.
    for (int i = 0; i < 14; i++) cyc(4'd2, 1'b0, 1'b0, 1'b0, VFetchWt, "fetch_stall_edge");
    cyc(4'd2, 1'b1, 1'b0, 1'b0, VFetchOk, "fetch_ready_at_limit");
    cyc(4'd2, 1'b1, 1'b0, 1'b0, VAdd, "add_after_edge");
    cyc(4'd2, 1'b1, 1'b0, 1'b0, VFetchOk, "fetch_no_fault");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
